// File: rtl/capture_pkg.sv
// Shared definitions for the logic-analyser capture engine: trigger modes,
// capture states and the trigger decision used on every WAIT sample.
package capture_pkg;

    localparam logic [1:0] TRIG_IMM  = 2'b00;
    localparam logic [1:0] TRIG_RISE = 2'b01;
    localparam logic [1:0] TRIG_FALL = 2'b10;
    localparam logic [1:0] TRIG_ANY  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT,
        ST_POST,
        ST_DONE
    } state_t;

    // Edge modes only mean something when a previous sample exists; the caller gates that.
    function automatic logic trig_fire(input logic [1:0] mode,
                                       input logic       prev_bit,
                                       input logic       cur_bit);
        logic fire;
        case (mode)
            TRIG_IMM:  fire = 1'b1;
            TRIG_RISE: fire = !prev_bit && cur_bit;
            TRIG_FALL: fire = prev_bit && !cur_bit;
            default:   fire = prev_bit != cur_bit;
        endcase
        return fire;
    endfunction

endpackage

// File: rtl/sample_sync.sv
// Synchronises the external sample clock and data into clk, and turns each
// rising edge of the sample clock into a one-cycle strobe with its sample.
module sample_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int CHANNELS    = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                smp_clk_in,
    input  logic [CHANNELS-1:0] data_in,
    output logic                strobe,
    output logic [CHANNELS-1:0] sample
);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [CHANNELS-1:0]    data_sync [SYNC_STAGES];
    logic                   clk_prev;

    // Data and clock take identical paths so the sample lines up with its strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_sync[i] <= '0;
            end
            clk_prev <= 1'b0;
            strobe   <= 1'b0;
            sample   <= '0;
        end else begin
            clk_sync     <= {clk_sync[SYNC_STAGES-2:0], smp_clk_in};
            data_sync[0] <= data_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                data_sync[i] <= data_sync[i-1];
            end
            clk_prev <= clk_sync[SYNC_STAGES-1];
            strobe   <= clk_sync[SYNC_STAGES-1] && !clk_prev;
            sample   <= data_sync[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/capture_engine.sv
// Multi-channel capture engine: pre-trigger history in a circular buffer,
// trigger on a selectable channel edge, trigger-aligned registered readback.
module capture_engine
    import capture_pkg::*;
#(
    parameter int CHANNELS    = 5,
    parameter int DEPTH       = 16,
    parameter int PRETRIG     = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              smp_clk_in,
    input  logic [CHANNELS-1:0]                               data_in,
    input  logic                                              arm,
    input  logic [1:0]                                        trig_mode,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] trig_ch,
    output logic                                              busy,
    output logic                                              done,
    input  logic [$clog2(DEPTH)-1:0]                          rd_addr,
    output logic [CHANNELS-1:0]                               rd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [AW-1:0] PRE_LAST = AW'(PRETRIG - 1);
    localparam logic [AW-1:0] PRE_OFS  = AW'(PRETRIG);
    localparam logic [AW-1:0] REM_INIT = AW'(DEPTH - PRETRIG - 1);

    state_t              state, state_next;
    logic                strobe;
    logic [CHANNELS-1:0] sample;
    logic [AW-1:0]       wr_ptr, start_ptr, remaining, rd_phys;
    logic                prev_valid, prev_bit, cur_bit;
    logic [1:0]          trig_mode_q;
    logic [TW-1:0]       trig_ch_q;
    logic                wr_en, fire;
    logic [CHANNELS-1:0] mem [DEPTH];

    sample_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .CHANNELS   (CHANNELS)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .smp_clk_in(smp_clk_in),
        .data_in   (data_in),
        .strobe    (strobe),
        .sample    (sample)
    );

    always_comb begin
        cur_bit = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (trig_ch_q == TW'(i)) begin
                cur_bit = sample[i];
            end
        end
    end

    // arm wins over everything, so a strobe coinciding with it is dropped.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        fire       = 1'b0;
        if (arm) begin
            state_next = (PRETRIG == 0) ? ST_WAIT : ST_PRE;
        end else if (strobe) begin
            case (state)
                ST_PRE: begin
                    wr_en = 1'b1;
                    if (wr_ptr == PRE_LAST) begin
                        state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wr_en = 1'b1;
                    fire  = trig_fire(trig_mode_q, prev_bit, cur_bit) &&
                            (prev_valid || trig_mode_q == TRIG_IMM);
                    if (fire) begin
                        state_next = (REM_INIT == '0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    wr_en = 1'b1;
                    if (remaining == AW'(1)) begin
                        state_next = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == ST_PRE) || (state_next == ST_WAIT) ||
                     (state_next == ST_POST);
            done  <= (state_next == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            start_ptr   <= '0;
            remaining   <= '0;
            prev_valid  <= 1'b0;
            prev_bit    <= 1'b0;
            trig_mode_q <= TRIG_IMM;
            trig_ch_q   <= '0;
        end else if (arm) begin
            wr_ptr      <= '0;
            prev_valid  <= 1'b0;
            trig_mode_q <= trig_mode;
            trig_ch_q   <= trig_ch;
        end else if (wr_en) begin
            wr_ptr     <= wr_ptr + AW'(1);
            prev_valid <= 1'b1;
            prev_bit   <= cur_bit;
            if (fire) begin
                start_ptr <= wr_ptr - PRE_OFS;
                remaining <= REM_INIT;
            end else if (state == ST_POST) begin
                remaining <= remaining - AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= sample;
        end
    end

    assign rd_phys = start_ptr + rd_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_phys];
        end
    end

endmodule

// File: tb/tb_capture_engine.sv
// Directed bench for capture_engine: table of read-back expectations per
// capture scenario plus hand-written sequences for abort, reset and PRETRIG=0.
module tb_capture_engine;
    import capture_pkg::*;

    typedef struct {
        int         phase;
        int         addr;
        logic [4:0] exp;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       smp_a = 1'b0;
    logic [4:0] data_a = '0;
    logic       arm_a = 1'b0;
    logic [1:0] mode_a = '0;
    logic [2:0] ch_a = '0;
    logic       busy_a, done_a;
    logic [3:0] rd_addr_a = '0;
    logic [4:0] rd_data_a;

    logic       smp_b = 1'b0;
    logic [4:0] data_b = '0;
    logic       arm_b = 1'b0;
    logic [1:0] mode_b = '0;
    logic [2:0] ch_b = '0;
    logic       busy_b, done_b;
    logic [2:0] rd_addr_b = '0;
    logic [4:0] rd_data_b;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    capture_engine #(.CHANNELS(5), .DEPTH(16), .PRETRIG(3), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .smp_clk_in(smp_a), .data_in(data_a),
        .arm(arm_a), .trig_mode(mode_a), .trig_ch(ch_a),
        .busy(busy_a), .done(done_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a)
    );

    capture_engine #(.CHANNELS(5), .DEPTH(8), .PRETRIG(0), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .smp_clk_in(smp_b), .data_in(data_b),
        .arm(arm_b), .trig_mode(mode_b), .trig_ch(ch_b),
        .busy(busy_b), .done(done_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int inst, input int addr);
        @(negedge clk);
        if (inst == 0) rd_addr_a = 4'(addr);
        else           rd_addr_b = 3'(addr);
        @(negedge clk);
    endtask

    // One sample-clock period: data settles, clock high 4 cycles, low again.
    task automatic send_sample(input int inst, input logic [4:0] d);
        @(negedge clk);
        if (inst == 0) data_a = d; else data_b = d;
        repeat (3) @(negedge clk);
        if (inst == 0) smp_a = 1'b1; else smp_b = 1'b1;
        repeat (4) @(negedge clk);
        if (inst == 0) smp_a = 1'b0; else smp_b = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_arm(input int inst, input logic [1:0] mode, input logic [2:0] ch);
        @(negedge clk);
        if (inst == 0) begin mode_a = mode; ch_a = ch; arm_a = 1'b1; end
        else           begin mode_b = mode; ch_b = ch; arm_b = 1'b1; end
        @(negedge clk);
        arm_a = 1'b0;
        arm_b = 1'b0;
    endtask

    task automatic run_phase(input int ph, input int inst);
        foreach (tbl[i]) begin
            if (tbl[i].phase == ph) begin
                applyStimulus(inst, tbl[i].addr);
                checkOutput(tbl[i].name, (inst == 0) ? rd_data_a : rd_data_b, tbl[i].exp);
            end
        end
    endtask

    initial begin
        tbl.push_back('{1, 0,  5'd0,  "imm_rd0"});
        tbl.push_back('{1, 3,  5'd3,  "imm_rd3"});
        tbl.push_back('{1, 5,  5'd5,  "imm_rd5"});
        tbl.push_back('{1, 15, 5'd15, "imm_rd15"});
        tbl.push_back('{2, 0,  5'd0,  "imm_17th_rd0"});
        tbl.push_back('{2, 15, 5'd15, "imm_17th_rd15"});
        tbl.push_back('{3, 0,  5'd14, "rise_rd0"});
        tbl.push_back('{3, 1,  5'd16, "rise_rd1"});
        tbl.push_back('{3, 2,  5'd18, "rise_rd2"});
        tbl.push_back('{3, 3,  5'd21, "rise_rd3"});
        tbl.push_back('{3, 15, 5'd13, "rise_rd15"});
        tbl.push_back('{4, 0,  5'd13, "fall_rd0"});
        tbl.push_back('{4, 1,  5'd14, "fall_rd1"});
        tbl.push_back('{4, 2,  5'd15, "fall_rd2"});
        tbl.push_back('{4, 3,  5'd16, "fall_rd3"});
        tbl.push_back('{4, 15, 5'd8,  "fall_rd15"});
        tbl.push_back('{5, 0,  5'd15, "abort_rd0"});
        tbl.push_back('{5, 3,  5'd12, "abort_rd3"});
        tbl.push_back('{5, 15, 5'd0,  "abort_rd15"});
        tbl.push_back('{6, 0,  5'd31, "rst_rd0"});
        tbl.push_back('{6, 5,  5'd26, "rst_rd5"});
        tbl.push_back('{6, 6,  5'd9,  "rst_rd6"});
        tbl.push_back('{7, 0,  5'd19, "any_rd0"});
        tbl.push_back('{7, 1,  5'd20, "any_rd1"});
        tbl.push_back('{7, 4,  5'd23, "any_rd4"});
        tbl.push_back('{7, 7,  5'd26, "any_rd7"});

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", busy_a, 1'b0);
        checkOutput("reset_done", done_a, 1'b0);
        checkOutput("reset_rd_data", rd_data_a, 5'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Immediate trigger, data is the sample count.
        pulse_arm(0, TRIG_IMM, 3'd0);
        checkOutput("imm_busy_after_arm", busy_a, 1'b1);
        checkOutput("imm_done_after_arm", done_a, 1'b0);
        for (int i = 0; i < 15; i++) send_sample(0, 5'(i));
        checkOutput("imm_done_before_last", done_a, 1'b0);
        send_sample(0, 5'd15);
        checkOutput("imm_done", done_a, 1'b1);
        checkOutput("imm_busy_low", busy_a, 1'b0);
        run_phase(1, 0);
        send_sample(0, 5'd16);
        checkOutput("imm_17th_done", done_a, 1'b1);
        run_phase(2, 0);

        // Rising edge on ch0 at sample 10; upper bits carry the sample index.
        pulse_arm(0, TRIG_RISE, 3'd0);
        for (int i = 0; i < 22; i++) send_sample(0, {4'(i), (i >= 10)});
        checkOutput("rise_done_before_last", done_a, 1'b0);
        send_sample(0, {4'(22), 1'b1});
        checkOutput("rise_done", done_a, 1'b1);
        run_phase(3, 0);

        // Falling edge on ch2 after 40 high samples, wrapping the buffer.
        pulse_arm(0, TRIG_FALL, 3'd2);
        for (int i = 0; i < 53; i++) begin
            logic [3:0] ix;
            ix = 4'(i);
            send_sample(0, {ix[3:2], (i < 40), ix[1:0]});
        end
        checkOutput("fall_done", done_a, 1'b1);
        run_phase(4, 0);

        // Re-arm during POST: old capture (bit4 set) must be abandoned.
        pulse_arm(0, TRIG_IMM, 3'd0);
        for (int i = 0; i < 6; i++) send_sample(0, 5'(16 + i));
        checkOutput("abort_busy_in_post", busy_a, 1'b1);
        pulse_arm(0, TRIG_IMM, 3'd0);
        checkOutput("abort_busy_after_rearm", busy_a, 1'b1);
        checkOutput("abort_done_after_rearm", done_a, 1'b0);
        for (int i = 0; i < 11; i++) send_sample(0, 5'(15 - i));
        checkOutput("abort_done_at_old_end", done_a, 1'b0);
        checkOutput("abort_busy_at_old_end", busy_a, 1'b1);
        for (int i = 11; i < 15; i++) send_sample(0, 5'(15 - i));
        checkOutput("abort_done_before_last", done_a, 1'b0);
        send_sample(0, 5'd0);
        checkOutput("abort_done", done_a, 1'b1);
        run_phase(5, 0);
        for (int k = 3; k < 16; k++) begin
            applyStimulus(0, k);
            checkOutput("abort_no_old_sample", rd_data_a[4], 1'b0);
        end

        // Reset in the middle of POST; strobes afterwards must not write.
        pulse_arm(0, TRIG_IMM, 3'd0);
        for (int i = 0; i < 6; i++) send_sample(0, 5'(31 - i));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", busy_a, 1'b0);
        checkOutput("rst_done", done_a, 1'b0);
        checkOutput("rst_rd_data", rd_data_a, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) send_sample(0, 5'd0);
        checkOutput("rst_busy_after", busy_a, 1'b0);
        checkOutput("rst_done_after", done_a, 1'b0);
        run_phase(6, 0);

        // PRETRIG=0, DEPTH=8, any edge on ch4; pre-arm data has ch4 high.
        send_sample(1, 5'h10);
        send_sample(1, 5'h10);
        pulse_arm(1, TRIG_ANY, 3'd4);
        checkOutput("any_busy_after_arm", busy_b, 1'b1);
        for (int i = 0; i < 3; i++) send_sample(1, 5'(i));
        for (int i = 3; i < 10; i++) send_sample(1, 5'(16 + i));
        checkOutput("any_done_before_last", done_b, 1'b0);
        send_sample(1, 5'(26));
        checkOutput("any_done", done_b, 1'b1);
        checkOutput("any_busy_low", busy_b, 1'b0);
        run_phase(7, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
